seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Sequential 16x16 unsigned shift-add multiplier that serves the ALU's multiply path. The ALU converts its signed operands to magnitudes, drives them on `mul1` and `mul2`, and applies the sign correction itself. This block computes the unsigned product over a fixed number of cycles and returns it on `mulresult`, holding the value for the ALU's second execute phase. It sits beside the ALU in the CPU datapath and is controlled by the state machine through a start/busy/done handshake.

## Interface
- `WIDTH`, default 16: operand width. The product width is 2*WIDTH.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a multiply; sampled on a rising edge only while idle.
- `mul1`  input  WIDTH  multiplicand (unsigned magnitude from the ALU).
- `mul2`  input  WIDTH  multiplier (unsigned magnitude from the ALU).
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse: `mulresult` has just been updated.
- `mulresult`  output  2*WIDTH  last completed product; registered and held.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: iterating.
  - DONE: one cycle; `done`=1, `busy`=0.
- IDLE → RUN when `start`=1:
  - latch `mul1` into A and `mul2` into B;
  - clear the accumulator P (WIDTH+1 bits);
  - load the iteration counter with WIDTH.
- RUN, each edge performs one iteration:
  - compute S = P + (B[0] ? A : 0), WIDTH+1 bits, so the carry is kept;
  - shift {S, B} right by 1: the LSB of S enters B's MSB, and P takes S shifted right with 0 in its MSB;
  - decrement the counter.
- RUN → DONE on the edge that completes iteration WIDTH. On that same edge, `mulresult` is loaded with {P, B} after the final shift, lower 2*WIDTH bits.
- DONE → RUN if `start`=1 on that edge (back-to-back operation accepted); otherwise DONE → IDLE.
- There is no early termination. Every operation takes exactly WIDTH iterations, including zero operands.
- `start` during RUN is ignored. Operand changes after the accepting edge have no effect.
- `mulresult` changes only at completion. It holds the previous product throughout a new operation.
- Arithmetic is unsigned modulo 2^(2*WIDTH). No overflow is possible, since the maximum is (2^W−1)^2.

## Timing
- Reset values (asynchronous, immediate on `reset_n`=0): state IDLE, `busy`=0, `done`=0, `mulresult`=0, A/B/P/counter=0.
- Reset in the middle of an operation aborts it. No `done` pulse is produced and `mulresult` returns to 0.
- Edge sequence (E0 = the edge at which `start` is sampled high in IDLE or DONE):
  - `busy`=1 in the cycles after E0 through E_WIDTH, i.e. 16 cycles for WIDTH=16.
  - At E_WIDTH, `mulresult` becomes valid, and in the following cycle `done`=1 and `busy`=0.
  - Latency from start to done is WIDTH+1 edges. Throughput is one product per WIDTH+1 cycles when back-to-back.
- `done` is high for exactly one cycle per completed operation.
- `busy` and `done` are never high together.
- The ALU samples `mulresult` during or after the `done` cycle. The value is stable until the next completion or reset.

## Test plan
- Reset: assert `reset_n`=0 mid-run (8 edges after start of 0x1234 x 0x5678) → `busy`=0, `done`=0, `mulresult`=0x00000000, no later `done`.
- Basic: `mul1`=3, `mul2`=5, pulse `start` → `busy` for 16 cycles, then `done` for one cycle with `mulresult`=0x0000000F.
- Extremes: 0xFFFF x 0xFFFF → 0xFFFE0001. 0x0000 x 0xBEEF → 0x00000000, still 17-edge latency. 0x8000 x 0x0002 → 0x00010000.
- Ignore while busy: start 0x0010 x 0x0010, re-pulse `start` with 0x0003 x 0x0003 at edge 5, change operands mid-run → single `done`, `mulresult`=0x00000100.
- Back-to-back: hold `start` high through the `done` cycle with new operands 0x00FF x 0x0101 → second operation begins immediately. The first result (previous product) holds until the second `done`, then `mulresult`=0x0000FFFF.
- Random: 1000 random operand pairs compared against a reference product, checking that `done` width is 1 and that `busy`/`done` are mutually exclusive every cycle.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier for the ALU multiply path.
// One partial-product iteration per clock; product held on mulresult until the next completion.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mul1,
  input  logic [WIDTH-1:0]     mul2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   mulresult
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one shift-add iteration per edge, counter counts down from WIDTH
  // DONE  | single cycle, mulresult freshly updated; start here restarts at once
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH:0]       r_p;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_mulresult;

  logic [WIDTH:0]       w_sum;
  logic                 w_load;
  logic                 w_last;

  // P never exceeds WIDTH significant bits after a shift, so WIDTH+1 bits hold the carry.
  assign w_sum  = r_p + (r_b[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last = (r_state == RUN) && (r_cnt == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_mulresult <= '0;
    end else if (w_load) begin
      r_a   <= mul1;
      r_b   <= mul2;
      r_p   <= '0;
      r_cnt <= CW'(WIDTH);
    end else if (r_state == RUN) begin
      r_p   <= {1'b0, w_sum[WIDTH:1]};
      r_b   <= {w_sum[0], r_b[WIDTH-1:1]};
      r_cnt <= r_cnt - CW'(1);
      // Lower 2*WIDTH bits of {P, B} after the final shift.
      if (w_last) begin
        r_mulresult <= {w_sum, r_b[WIDTH-1:1]};
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign mulresult = r_mulresult;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector and random bench for seq_multiplier.
// Drives and samples on the falling edge; expected products come from the vector table or 32-bit multiply.
module tb_seq_multiplier;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] mul1;
  logic [15:0] mul2;
  logic        busy;
  logic        done;
  logic [31:0] mulresult;

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;
  int excl_viol   = 0;
  int width_viol  = 0;
  logic prev_done = 1'b0;

  seq_multiplier #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mul1      (mul1),
    .mul2      (mul2),
    .busy      (busy),
    .done      (done),
    .mulresult (mulresult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) excl_viol++;
    if (done && prev_done) width_viol++;
    if (done) done_pulses++;
    prev_done = done;
  end

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one operation from IDLE; checks busy length, held result, product and done width.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input logic [31:0] prev);
    int nb;
    int n;
    logic held_ok;
    @(negedge clk);
    mul1 = a; mul2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mul1 = ~a; mul2 = ~b;
    nb = 0; n = 0; held_ok = 1'b1;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (mulresult !== prev) held_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({name, " done_seen"}, {31'd0, done}, 32'd1);
    chk({name, " busy_cycles"}, nb, 32'd16);
    chk({name, " held"}, {31'd0, held_ok}, 32'd1);
    chk({name, " product"}, mulresult, exp);
    @(negedge clk);
    chk({name, " done_width"}, {31'd0, done}, 32'd0);
    chk({name, " result_hold"}, mulresult, exp);
  endtask

  initial begin
    logic [31:0] last;
    int          pulses0;
    int          nb;
    int          n;
    logic        held_ok;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{"basic",    16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{"max",      16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{"zero",     16'h0000, 16'hBEEF, 32'h00000000};
    vecs[3] = '{"msb",      16'h8000, 16'h0002, 32'h00010000};
    vecs[4] = '{"mixed",    16'h1234, 16'h5678, 32'h06260060};
    vecs[5] = '{"one",      16'h0001, 16'hABCD, 32'h0000ABCD};

    reset_n = 1'b0; start = 1'b0; mul1 = '0; mul2 = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", mulresult, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    last = 32'd0;
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p, last);
      last = vecs[i].p;
    end

    // Start re-pulsed at edge 5 with other operands must be ignored.
    @(negedge clk);
    mul1 = 16'h0010; mul2 = 16'h0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses0 = done_pulses;
    repeat (4) @(negedge clk);
    mul1 = 16'h0003; mul2 = 16'h0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mul1 = 16'h7777; mul2 = 16'h9999;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("ignore product", mulresult, 32'h00000100);
    repeat (25) @(negedge clk);
    chk("ignore single_done", done_pulses - pulses0, 32'd1);
    last = 32'h00000100;

    // Back-to-back: start held high through the done cycle.
    @(negedge clk);
    mul1 = 16'h1234; mul2 = 16'h0002; start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("b2b first", mulresult, 32'h00002468);
    mul1 = 16'h00FF; mul2 = 16'h0101;
    @(negedge clk);
    start = 1'b0;
    nb = 0; n = 0; held_ok = 1'b1;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (mulresult !== 32'h00002468) held_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("b2b busy_cycles", nb, 32'd16);
    chk("b2b held", {31'd0, held_ok}, 32'd1);
    chk("b2b second", mulresult, 32'h0000FFFF);
    last = 32'h0000FFFF;

    // Reset 8 edges into an operation.
    @(negedge clk);
    @(negedge clk);
    mul1 = 16'h1234; mul2 = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    pulses0 = done_pulses;
    reset_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst result", mulresult, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst no_done", done_pulses - pulses0, 32'd0);
    chk("midrst result_after", mulresult, 32'd0);

    // Random operands against a full-width reference multiply.
    last = 32'd0;
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k == 0) ra = 16'hFFFF;
      run_op("rand", ra, rb, 32'(ra) * 32'(rb), last);
      last = 32'(ra) * 32'(rb);
    end

    chk("busy_done_exclusive", excl_viol, 32'd0);
    chk("done_one_cycle", width_viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
